// File: rtl/hist_pkg.sv
// Shared types and helpers for the streaming histogram accumulator.
package hist_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DUMP  = 2'd2
  } hist_state_e;

  // Saturating add returning {overflow, clamped sum}; width must be below 32.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    if (sum > lim) return {1'b1, lim[31:0]};
    return {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// Simple dual-port bin storage: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module hist_bin_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port and read-first registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hist_accum_stream.sv
// Streaming pixel histogram: clears bins, accumulates a frame, then streams
// the bins (or their running sum) out while zeroing them for the next frame.
module hist_accum_stream
  import hist_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 21,
  parameter int CDF_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_img_vsync,
  input  logic              pre_img_valid,
  input  logic [DATA_W-1:0] pre_img_gray,
  output logic [DATA_W-1:0] hist_bin,
  output logic [CNT_W-1:0]  hist_cnt,
  output logic              hist_vld,
  input  logic              hist_rdy,
  output logic              hist_last,
  output logic              busy,
  output logic              drop_err,
  output logic              sat_err
);

  localparam logic [DATA_W-1:0] LAST_BIN = {DATA_W{1'b1}};

  hist_state_e       state_q, state_d;
  logic              vsync_d, vsync_fall, acc_hit, last_hs;
  logic [DATA_W-1:0] clr_ptr;
  logic              s1_vld;
  logic [DATA_W-1:0] s1_addr;
  logic              fwd_vld;
  logic [DATA_W-1:0] fwd_addr;
  logic [CNT_W-1:0]  fwd_data;
  logic [CNT_W-1:0]  rd_data, operand, inc_val, cum_q, cum_next;
  logic [32:0]       inc_res, cum_res;
  logic              inc_ovf, cum_ovf;
  logic              f_vld, fetch_done, load;
  logic [DATA_W-1:0] f_addr, dump_raddr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0]  ram_wdata;

  assign busy       = (state_q != ST_ACCUM);
  assign vsync_fall = vsync_d & ~pre_img_vsync;
  assign acc_hit    = (state_q == ST_ACCUM) && pre_img_valid && pre_img_vsync;
  assign last_hs    = hist_vld && hist_rdy && hist_last;
  assign load       = (state_q == ST_DUMP) && f_vld && (!hist_vld || hist_rdy);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  // Next state; no pixel is accepted on the fall cycle, so the pipeline has
  // drained by the time DUMP issues its first read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_ptr == LAST_BIN) state_d = ST_ACCUM;
      ST_ACCUM: if (vsync_fall)          state_d = ST_DUMP;
      ST_DUMP:  if (last_hs)             state_d = ST_ACCUM;
      default:                           state_d = ST_CLEAR;
    endcase
  end

  // Clear pointer walks every bin once while in CLEAR
  always_ff @(posedge clk) begin
    if (rst)                        clr_ptr <= '0;
    else if (state_q == ST_CLEAR)   clr_ptr <= clr_ptr + 1'b1;
    else                            clr_ptr <= '0;
  end

  // Vsync history and the read stage of the increment pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d <= 1'b0;
      s1_vld  <= 1'b0;
      s1_addr <= '0;
    end else begin
      vsync_d <= pre_img_vsync;
      s1_vld  <= acc_hit;
      s1_addr <= pre_img_gray;
    end
  end

  // Remember the last RAM write; its read-first port cannot see it yet
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_vld  <= 1'b0;
      fwd_addr <= '0;
      fwd_data <= '0;
    end else begin
      fwd_vld  <= ram_we;
      fwd_addr <= ram_waddr;
      fwd_data <= ram_wdata;
    end
  end

  // Saturating increment with forwarding, and the saturating running sum
  always_comb begin
    operand  = (fwd_vld && (fwd_addr == s1_addr)) ? fwd_data : rd_data;
    inc_res  = sat_add(32'(operand), 32'd1, CNT_W);
    inc_ovf  = inc_res[32];
    inc_val  = CNT_W'(inc_res);
    cum_res  = sat_add(32'(cum_q), 32'(rd_data), CNT_W);
    cum_ovf  = cum_res[32];
    cum_next = CNT_W'(cum_res);
  end

  // RAM port steering: zero fill, increment write-back, or zero-on-read
  always_comb begin
    ram_we     = 1'b0;
    ram_waddr  = clr_ptr;
    ram_wdata  = '0;
    ram_raddr  = '0;
    dump_raddr = load ? (f_addr + 1'b1) : f_addr;
    case (state_q)
      ST_CLEAR: ram_we = 1'b1;
      ST_ACCUM: begin
        ram_we    = s1_vld;
        ram_waddr = s1_addr;
        ram_wdata = inc_val;
        ram_raddr = pre_img_gray;
      end
      ST_DUMP: begin
        ram_we    = load;
        ram_waddr = f_addr;
        ram_raddr = dump_raddr;
      end
      default: ram_we = 1'b0;
    endcase
  end

  // Readout fetch tracking: f_addr is the bin whose data sits on rd_data
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_DUMP) begin
      f_vld      <= 1'b0;
      f_addr     <= '0;
      fetch_done <= 1'b0;
    end else if (!f_vld && !fetch_done) begin
      f_vld <= 1'b1;
    end else if (load) begin
      if (f_addr == LAST_BIN) begin
        f_vld      <= 1'b0;
        fetch_done <= 1'b1;
      end else begin
        f_addr <= f_addr + 1'b1;
      end
    end
  end

  // Output beat register; holds while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld  <= 1'b0;
      hist_bin  <= '0;
      hist_cnt  <= '0;
      hist_last <= 1'b0;
    end else if (load) begin
      hist_vld  <= 1'b1;
      hist_bin  <= f_addr;
      hist_cnt  <= (CDF_MODE != 0) ? cum_next : rd_data;
      hist_last <= (f_addr == LAST_BIN);
    end else if (hist_rdy) begin
      hist_vld  <= 1'b0;
      hist_last <= 1'b0;
    end
  end

  // Running sum restarts with each readout
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_DUMP) cum_q <= '0;
    else if (load)                 cum_q <= cum_next;
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err <= 1'b0;
      sat_err  <= 1'b0;
    end else begin
      if (pre_img_valid && state_q != ST_ACCUM) drop_err <= 1'b1;
      if (state_q == ST_ACCUM && s1_vld && inc_ovf) sat_err <= 1'b1;
      if (load && (CDF_MODE != 0) && cum_ovf) sat_err <= 1'b1;
    end
  end

  hist_bin_ram #(
    .ADDR_W(DATA_W),
    .DATA_W(CNT_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_hist_accum_stream.sv
// Bench for hist_accum_stream: three instances (default, cumulative, 4-bit
// counters) share one pixel stream and are checked against a frame histogram.
module tb_hist_accum_stream;

  localparam int MAXW = (1 << 21) - 1;
  localparam int MAXS = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       pre_img_vsync, pre_img_valid, hist_rdy;
  logic [7:0] pre_img_gray;

  logic [7:0]  a_bin, c_bin, s_bin;
  logic [20:0] a_cnt, c_cnt;
  logic [3:0]  s_cnt;
  logic a_vld, a_last, a_busy, a_drop, a_sat;
  logic c_vld, c_last, c_busy, c_drop, c_sat;
  logic s_vld, s_last, s_busy, s_drop, s_sat;

  int checks = 0;
  int errors = 0;
  int h[256];
  bit expDrop = 0;
  bit expSatS = 0;
  bit expSatC = 0;

  always #5 clk = ~clk;

  hist_accum_stream #(.DATA_W(8), .CNT_W(21), .CDF_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .pre_img_vsync(pre_img_vsync), .pre_img_valid(pre_img_valid),
    .pre_img_gray(pre_img_gray), .hist_bin(a_bin), .hist_cnt(a_cnt), .hist_vld(a_vld),
    .hist_rdy(hist_rdy), .hist_last(a_last), .busy(a_busy), .drop_err(a_drop), .sat_err(a_sat));

  hist_accum_stream #(.DATA_W(8), .CNT_W(21), .CDF_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .pre_img_vsync(pre_img_vsync), .pre_img_valid(pre_img_valid),
    .pre_img_gray(pre_img_gray), .hist_bin(c_bin), .hist_cnt(c_cnt), .hist_vld(c_vld),
    .hist_rdy(hist_rdy), .hist_last(c_last), .busy(c_busy), .drop_err(c_drop), .sat_err(c_sat));

  hist_accum_stream #(.DATA_W(8), .CNT_W(4), .CDF_MODE(0)) dut_s (
    .clk(clk), .rst(rst), .pre_img_vsync(pre_img_vsync), .pre_img_valid(pre_img_valid),
    .pre_img_gray(pre_img_gray), .hist_bin(s_bin), .hist_cnt(s_cnt), .hist_vld(s_vld),
    .hist_rdy(hist_rdy), .hist_last(s_last), .busy(s_busy), .drop_err(s_drop), .sat_err(s_sat));

  function automatic int minI(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accumulate cycle with vsync high; valid pixels enter the model
  task automatic applyStimulus(input bit v, input logic [7:0] g);
    pre_img_vsync = 1'b1;
    pre_img_valid = v;
    pre_img_gray  = g;
    if (v) h[g]++;
    @(negedge clk);
  endtask

  task automatic randomPixels(input int n);
    for (int i = 0; i < n; i++) begin
      bit v;
      logic [7:0] g;
      v = ($urandom_range(0, 3) != 0);
      g = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      applyStimulus(v, g);
    end
  endtask

  // Drop vsync, then check every readout beat against the frame histogram
  task automatic dumpFrame(input bit randRdy, input bit inject);
    int lat, k, cyc, cum;
    bit stall, rdy;
    logic [7:0]  sBin;
    logic [20:0] sCnt, sCdf;
    logic        sLast;
    stall = 0; k = 0; cyc = 0; cum = 0;
    sBin = '0; sCnt = '0; sCdf = '0; sLast = 1'b0;
    pre_img_vsync = 1'b0;
    pre_img_valid = 1'b0;
    hist_rdy      = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!a_vld && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("first_vld_within_4", 32'(lat <= 4), 1);
    while (k < 256 && cyc < 4000) begin
      if (stall) begin
        checkOutput("stall_vld", a_vld, 1);
        checkOutput("stall_bin", a_bin, sBin);
        checkOutput("stall_cnt", a_cnt, sCnt);
        checkOutput("stall_last", a_last, sLast);
        checkOutput("stall_cdf", c_cnt, sCdf);
      end
      stall = 0;
      rdy = randRdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      hist_rdy = rdy;
      if (a_vld) begin
        if (rdy) begin
          cum += h[k];
          checkOutput("beat_bin", a_bin, k);
          checkOutput("beat_cnt", a_cnt, minI(h[k], MAXW));
          checkOutput("beat_last", a_last, (k == 255));
          checkOutput("cdf_vld", c_vld, 1);
          checkOutput("cdf_bin", c_bin, k);
          checkOutput("cdf_cnt", c_cnt, minI(cum, MAXW));
          checkOutput("cdf_last", c_last, (k == 255));
          checkOutput("s4_vld", s_vld, 1);
          checkOutput("s4_bin", s_bin, k);
          checkOutput("s4_cnt", s_cnt, minI(h[k], MAXS));
          checkOutput("s4_last", s_last, (k == 255));
          if (h[k] > MAXS) expSatS = 1;
          if (cum > MAXW) expSatC = 1;
          k++;
        end else begin
          stall = 1;
          sBin = a_bin; sCnt = a_cnt; sLast = a_last; sCdf = c_cnt;
        end
      end
      if (inject && k >= 20 && k < 200) begin
        pre_img_valid = (k == 20) || ($urandom_range(0, 1) == 1);
        pre_img_gray  = 8'($urandom_range(0, 255));
        if (pre_img_valid) expDrop = 1;
        if (k >= 100) pre_img_vsync = 1'b1;
      end else begin
        pre_img_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("beat_total", k, 256);
    hist_rdy = 1'b1;
    pre_img_valid = 1'b0;
    checkOutput("post_dump_vld", a_vld, 0);
    checkOutput("post_dump_busy", a_busy, 0);
    checkOutput("post_dump_busy_cdf", c_busy, 0);
    checkOutput("post_dump_busy_s4", s_busy, 0);
    checkOutput("drop_err", a_drop, expDrop);
    checkOutput("drop_err_cdf", c_drop, expDrop);
    checkOutput("drop_err_s4", s_drop, expDrop);
    checkOutput("sat_err", a_sat, 0);
    checkOutput("sat_err_cdf", c_sat, expSatC);
    checkOutput("sat_err_s4", s_sat, expSatS);
    for (int i = 0; i < 256; i++) h[i] = 0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) h[i] = 0;
    rst = 1'b1;
    pre_img_vsync = 1'b0;
    pre_img_valid = 1'b0;
    pre_img_gray  = '0;
    hist_rdy      = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_vld", a_vld, 0);
    checkOutput("rst_bin", a_bin, 0);
    checkOutput("rst_cnt", a_cnt, 0);
    checkOutput("rst_last", a_last, 0);
    checkOutput("rst_busy", a_busy, 1);
    checkOutput("rst_drop", a_drop, 0);
    checkOutput("rst_sat", a_sat, 0);
    checkOutput("rst_busy_cdf", c_busy, 1);
    checkOutput("rst_busy_s4", s_busy, 1);

    rst = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (a_busy && cnt < 400);
    checkOutput("clear_busy_cycles", cnt, 256);

    $display("[TB] frame: 20 pixels of 9 (4-bit counter saturation)");
    repeat (20) applyStimulus(1'b1, 8'd9);
    applyStimulus(1'b0, 8'd0);
    dumpFrame(1'b0, 1'b0);

    $display("[TB] frame: 100 pixels of 7");
    repeat (100) applyStimulus(1'b1, 8'd7);
    dumpFrame(1'b0, 1'b0);

    $display("[TB] frame: 3,3,4,3 x50 forwarding");
    repeat (50) begin
      applyStimulus(1'b1, 8'd3);
      applyStimulus(1'b1, 8'd3);
      applyStimulus(1'b1, 8'd4);
      applyStimulus(1'b1, 8'd3);
    end
    dumpFrame(1'b0, 1'b0);

    $display("[TB] frame: one each of 0,1,2");
    applyStimulus(1'b1, 8'd0);
    applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b1, 8'd1);
    applyStimulus(1'b1, 8'd2);
    dumpFrame(1'b0, 1'b0);

    $display("[TB] frame: no valid pixels");
    repeat (4) applyStimulus(1'b0, 8'd0);
    dumpFrame(1'b0, 1'b0);

    $display("[TB] frame: random pixels, stalling sink, pixels during readout");
    randomPixels(300);
    dumpFrame(1'b1, 1'b1);

    $display("[TB] frame: random pixels after dropped ones");
    randomPixels(200);
    dumpFrame(1'b1, 1'b0);

    $display("[TB] reset in the middle of accumulation");
    randomPixels(60);
    rst = 1'b1;
    pre_img_vsync = 1'b0;
    pre_img_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_busy", a_busy, 1);
    checkOutput("midrst_drop", a_drop, 0);
    checkOutput("midrst_sat_s4", s_sat, 0);
    checkOutput("midrst_vld", a_vld, 0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) h[i] = 0;
    expDrop = 0;
    expSatS = 0;
    expSatC = 0;
    cnt = 0;
    while (a_busy && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("midrst_clear_done", a_busy, 0);
    randomPixels(80);
    dumpFrame(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_accum_stream.md
HIST_ACCUM_STREAM -- requirements
Module: hist_accum_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel width; bin count N = 2^DATA_W.
REQ-002 SHALL have parameter CNT_W, default 21, meaning bin counter width.
REQ-003 SHALL have parameter CDF_MODE, default 0, meaning 0 = per-bin histogram, 1 = cumulative histogram.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port pre_img_vsync, input, 1 bit, high while a frame is active.
REQ-007 SHALL have port pre_img_valid, input, 1 bit, pixel qualifier.
REQ-008 SHALL have port pre_img_gray, input, DATA_W bits, pixel value.
REQ-009 SHALL have port hist_bin, output, DATA_W bits, bin index of the readout beat.
REQ-010 SHALL have port hist_cnt, output, CNT_W bits, bin count or cumulative count.
REQ-011 SHALL have port hist_vld, output, 1 bit, readout beat valid.
REQ-012 SHALL have port hist_rdy, input, 1 bit, readout sink ready.
REQ-013 SHALL have port hist_last, output, 1 bit, marks bin N-1.
REQ-014 SHALL have port busy, output, 1 bit, high in CLEAR or DUMP.
REQ-015 SHALL have port drop_err, output, 1 bit, sticky; pixel arrived while not in ACCUM.
REQ-016 SHALL have port sat_err, output, 1 bit, sticky; a bin or cumulative sum saturated.

Function
REQ-017 SHALL implement FSM states CLEAR, ACCUM and DUMP.
REQ-018 CLEAR SHALL write zero to all N bins, one bin per cycle, for N cycles, then go to ACCUM.
REQ-019 In ACCUM, each cycle with pre_img_valid=1 and pre_img_vsync=1 SHALL increment bin[pre_img_gray] by 1.
REQ-020 Increments SHALL use a 2-stage read-modify-write pipeline.
REQ-021 Same-bin hits on consecutive cycles, or two cycles apart, SHALL be forwarded so that no increment is lost.
REQ-022 Bin counts SHALL saturate at 2^CNT_W-1 and set sat_err.
REQ-023 A falling edge of pre_img_vsync in ACCUM SHALL enter DUMP once the increment pipeline has drained.
REQ-024 The first hist_vld SHALL assert no later than 4 cycles after the falling edge.
REQ-025 DUMP SHALL emit bins 0..N-1 in ascending order, one beat per hist_vld&&hist_rdy.
REQ-026 While hist_vld=1 and hist_rdy=0, hist_bin, hist_cnt and hist_last SHALL hold stable.
REQ-027 In CDF_MODE=1, hist_cnt SHALL equal the running sum of bins 0..k, saturating at 2^CNT_W-1 and setting sat_err.
REQ-028 DUMP SHALL zero each bin as it is read out, so no separate CLEAR is needed between frames.
REQ-029 After the hist_last handshake, DUMP SHALL return to ACCUM on the next cycle.
REQ-030 Pixels arriving in CLEAR or DUMP SHALL be discarded and SHALL set drop_err.
REQ-031 A rising edge of pre_img_vsync during DUMP SHALL NOT abort the readout.
REQ-032 A frame with zero valid pixels SHALL still dump N beats, all counts 0.
REQ-033 drop_err and sat_err SHALL clear only on rst.

Reset
REQ-034 On rst, all outputs SHALL be 0 except busy, which SHALL be 1.
REQ-035 On rst, the FSM SHALL enter CLEAR.
REQ-036 rst mid-ACCUM or mid-DUMP SHALL discard all partial results and restart CLEAR.

Structure
REQ-037 Package hist_pkg SHALL hold the FSM state enum and the saturating-add helper function.
REQ-038 Bin storage SHALL be one sub-module, hist_bin_ram: simple dual-port RAM, N x CNT_W, 1-cycle read latency.

Verification
REQ-039 rst for 3 cycles, DATA_W=8 -> busy=1 for exactly 256 cycles after rst release, then 0.
REQ-040 100 consecutive valid pixels of value 7, then vsync fall, hist_rdy=1 -> beat 7 cnt=100; all other bins 0; hist_last only on bin 255.
REQ-041 Alternating pixels 3,3,4,3 repeated 50 times -> bin3=150, bin4=50 (forwarding check).
REQ-042 CDF_MODE=1, one pixel each of 0,1,2 -> hist_cnt 1,2,3,3,...,3; last beat = 3.
REQ-043 hist_rdy toggled randomly during DUMP, plus pixels injected during DUMP -> outputs stable while stalled, 256 beats total, drop_err=1, next frame counts exclude dropped pixels.
REQ-044 CNT_W=4 with 20 pixels of value 9 -> bin9=15, sat_err=1.
